// File: rtl/instr_steer_recv.sv
// Instruction receiver: steers app/maintenance instructions round-robin into NUM_CH slot FIFOs.
// Optional maintenance path enabled by defining SOFTMC_RECV_MAINT_EN.
module instr_steer_recv #(
    parameter int          NUM_CH     = 2,
    parameter logic [3:0]  END_OPCODE = 4'hF,
    parameter logic [31:0] PAD_INSTR  = 32'h0000_0000,
    parameter int          ROWS_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dispatcher_ready,
    input  logic                   rdback_fifo_empty,
    input  logic                   app_en,
    input  logic [31:0]            app_instr,
    output logic                   app_ack,
    input  logic                   maint_en,
    input  logic [31:0]            maint_instr,
    output logic                   maint_ack,
    output logic [NUM_CH-1:0]      instr_fifo_en,
    output logic [32*NUM_CH-1:0]   instr_fifo_data,
    input  logic [NUM_CH-1:0]      instr_fifo_full,
    output logic                   process_iseq,
    output logic [ROWS_W-1:0]      iseq_rows,
    output logic                   seq_err
);

    localparam int PTR_W = $clog2(NUM_CH);

    typedef enum logic [2:0] {
        IDLE,
        RECV_APP,
        PAD,
        ISSUE,
        WAIT_DONE
`ifdef SOFTMC_RECV_MAINT_EN
        , RECV_MAINT
`endif
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   ptr_nxt;
    logic               ptr_wrap;
    logic               sel_full;
    logic               src_en;
    logic               src_ack;
    logic [31:0]        src_instr;

    function automatic logic [ROWS_W-1:0] rows_sat_inc(input logic [ROWS_W-1:0] r);
        return (&r) ? r : r + ROWS_W'(1);
    endfunction

`ifndef SOFTMC_RECV_MAINT_EN
    logic maint_path_unused;
    assign maint_path_unused = ^{maint_en, maint_instr, rdback_fifo_empty};
`endif

    assign ptr_nxt  = wr_ptr + PTR_W'(1);
    assign ptr_wrap = (ptr_nxt == '0);
    assign sel_full = instr_fifo_full[wr_ptr];

    // The source being received is the only one looked at; the other is ignored.
    always_comb begin
        src_en    = 1'b0;
        src_ack   = 1'b0;
        src_instr = '0;
        if (state == RECV_APP) begin
            src_en    = app_en;
            src_ack   = app_ack;
            src_instr = app_instr;
        end
`ifdef SOFTMC_RECV_MAINT_EN
        if (state == RECV_MAINT) begin
            src_en    = maint_en;
            src_ack   = maint_ack;
            src_instr = maint_instr;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            app_ack         <= 1'b0;
            maint_ack       <= 1'b0;
            instr_fifo_en   <= '0;
            instr_fifo_data <= '0;
            process_iseq    <= 1'b0;
            iseq_rows       <= '0;
            seq_err         <= 1'b0;
        end else begin
            app_ack       <= 1'b0;
            maint_ack     <= 1'b0;
            instr_fifo_en <= '0;
            case (state)
                IDLE: begin
`ifdef SOFTMC_RECV_MAINT_EN
                    if (maint_en && dispatcher_ready && rdback_fifo_empty) begin
                        state     <= RECV_MAINT;
                        wr_ptr    <= '0;
                        iseq_rows <= '0;
                    end else
`endif
                    if (app_en && dispatcher_ready) begin
                        state     <= RECV_APP;
                        wr_ptr    <= '0;
                        iseq_rows <= '0;
                    end
                end

`ifdef SOFTMC_RECV_MAINT_EN
                RECV_APP, RECV_MAINT: begin
`else
                RECV_APP: begin
`endif
                    // The ack term blocks re-accepting the instruction just taken.
                    if (src_en && !src_ack) begin
                        if (sel_full) begin
                            seq_err <= 1'b1;
                        end else begin
                            instr_fifo_en[wr_ptr]             <= 1'b1;
                            instr_fifo_data[32*wr_ptr +: 32]  <= src_instr;
                            wr_ptr                            <= ptr_nxt;
                            if (ptr_wrap)
                                iseq_rows <= rows_sat_inc(iseq_rows);
`ifdef SOFTMC_RECV_MAINT_EN
                            if (state == RECV_MAINT)
                                maint_ack <= 1'b1;
                            else
`endif
                                app_ack <= 1'b1;
                            if (src_instr[31:28] == END_OPCODE)
                                state <= ptr_wrap ? ISSUE : PAD;
                        end
                    end
                end

                PAD: begin
                    if (!sel_full) begin
                        instr_fifo_en[wr_ptr]            <= 1'b1;
                        instr_fifo_data[32*wr_ptr +: 32] <= PAD_INSTR;
                        wr_ptr                           <= ptr_nxt;
                        if (ptr_wrap) begin
                            iseq_rows <= rows_sat_inc(iseq_rows);
                            state     <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    if (!dispatcher_ready) begin
                        process_iseq <= 1'b0;
                        state        <= WAIT_DONE;
                    end else begin
                        process_iseq <= 1'b1;
                    end
                end

                WAIT_DONE: begin
                    if (dispatcher_ready)
                        state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_steer_recv.sv
// Scoreboard bench for instr_steer_recv: expected FIFO writes queued at drive time, popped on instr_fifo_en.
module tb_instr_steer_recv;

    localparam int          NCH = 2;
    localparam logic [31:0] PAD = 32'h0000_0000;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               dispatcher_ready = 1'b1;
    logic               rdback_fifo_empty = 1'b1;
    logic               app_en = 1'b0;
    logic [31:0]        app_instr = '0;
    logic               app_ack;
    logic               maint_en = 1'b0;
    logic [31:0]        maint_instr = '0;
    logic               maint_ack;
    logic [NCH-1:0]     instr_fifo_en;
    logic [32*NCH-1:0]  instr_fifo_data;
    logic [NCH-1:0]     instr_fifo_full = '0;
    logic               process_iseq;
    logic [15:0]        iseq_rows;
    logic               seq_err;

    instr_steer_recv #(.NUM_CH(NCH), .END_OPCODE(4'hF), .PAD_INSTR(PAD), .ROWS_W(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .dispatcher_ready  (dispatcher_ready),
        .rdback_fifo_empty (rdback_fifo_empty),
        .app_en            (app_en),
        .app_instr         (app_instr),
        .app_ack           (app_ack),
        .maint_en          (maint_en),
        .maint_instr       (maint_instr),
        .maint_ack         (maint_ack),
        .instr_fifo_en     (instr_fifo_en),
        .instr_fifo_data   (instr_fifo_data),
        .instr_fifo_full   (instr_fifo_full),
        .process_iseq      (process_iseq),
        .iseq_rows         (iseq_rows),
        .seq_err           (seq_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0] en;
        logic [31:0]    data;
    } wr_t;

    wr_t exp_q[$];
    int  n_chk = 0;
    int  n_fail = 0;
    int  m_ptr = 0;
    int  m_rows = 0;
    int  maint_ack_cnt = 0;

    function automatic void push_wr(input logic [31:0] d);
        wr_t e;
        e.en   = NCH'(1) << m_ptr;
        e.data = d;
        exp_q.push_back(e);
        m_ptr = (m_ptr + 1) % NCH;
        if (m_ptr == 0) m_rows++;
    endfunction

    function automatic void push_instr(input logic [31:0] d);
        push_wr(d);
        if (d[31:28] == 4'hF)
            while (m_ptr != 0) push_wr(PAD);
    endfunction

    // Scoreboard: every FIFO write must match the next expected (slot, data)
    always @(negedge clk) begin
        if (!rst && instr_fifo_en != '0) begin
            wr_t         e;
            logic [31:0] got;
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL fifo_write unexpected: en=%b data=%h, none expected", instr_fifo_en, instr_fifo_data);
            end else begin
                e   = exp_q.pop_front();
                got = '0;
                for (int k = 0; k < NCH; k++)
                    if (e.en[k]) got = instr_fifo_data[32*k +: 32];
                if (instr_fifo_en !== e.en || got !== e.data) begin
                    n_fail++;
                    $display("FAIL fifo_write: got en=%b data=%h, expected en=%b data=%h", instr_fifo_en, got, e.en, e.data);
                end
            end
        end
        if (maint_ack) maint_ack_cnt++;
    end

    task automatic start_seq();
        m_ptr  = 0;
        m_rows = 0;
    endtask

    task automatic send(input bit is_maint, input logic [31:0] d, input string name);
        bit got;
        push_instr(d);
        if (is_maint) begin maint_en = 1'b1; maint_instr = d; end
        else          begin app_en = 1'b1;   app_instr = d;   end
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (is_maint ? maint_ack : app_ack) begin got = 1'b1; break; end
        end
        if (is_maint) maint_en = 1'b0; else app_en = 1'b0;
        n_chk++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s ack: got none within 30 cycles, expected ack", name);
        end
    endtask

    task automatic finish_seq(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (process_iseq) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        n_chk++;
        if (!seen) begin n_fail++; $display("FAIL %s process_iseq: got 0, expected 1", name); end
        n_chk++;
        if (iseq_rows !== 16'(m_rows)) begin
            n_fail++;
            $display("FAIL %s iseq_rows: got %0d, expected %0d", name, iseq_rows, m_rows);
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s writes_done: got %0d pending, expected 0", name, exp_q.size());
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
        n_chk++;
        if (process_iseq !== 1'b1) begin
            n_fail++;
            $display("FAIL %s process_held: got %b, expected 1", name, process_iseq);
        end
        dispatcher_ready = 1'b0;
        @(negedge clk);
        n_chk++;
        if (process_iseq !== 1'b0) begin
            n_fail++;
            $display("FAIL %s process_drop: got %b, expected 0", name, process_iseq);
        end
        dispatcher_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_chk++;
        if ({app_ack, maint_ack, instr_fifo_en} !== '0) begin
            n_fail++;
            $display("FAIL reset_acks: got %b, expected 0", {app_ack, maint_ack, instr_fifo_en});
        end
        n_chk++;
        if (instr_fifo_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h, expected 0", instr_fifo_data);
        end
        n_chk++;
        if ({process_iseq, iseq_rows, seq_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_status: got proc=%b rows=%0d err=%b, expected 0", process_iseq, iseq_rows, seq_err);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_app_seq();
        start_seq();
        send(1'b0, 32'h1000_0001, "app_seq_i0");
        send(1'b0, 32'h1000_0002, "app_seq_i1");
        send(1'b0, 32'hF000_0000, "app_seq_end");
        finish_seq("app_seq");
    endtask

    task automatic test_exact_fill();
        start_seq();
        for (int i = 0; i < NCH - 1; i++)
            send(1'b0, 32'h2000_0000 + 32'(i), "fill_instr");
        send(1'b0, 32'hF000_0011, "fill_end");
        n_chk++;
        if (process_iseq !== 1'b0 || iseq_rows !== 16'd1) begin
            n_fail++;
            $display("FAIL fill_at_end: got proc=%b rows=%0d, expected proc=0 rows=1", process_iseq, iseq_rows);
        end
        @(negedge clk);
        n_chk++;
        if (process_iseq !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_issue_latency: got %b, expected 1", process_iseq);
        end
        finish_seq("exact_fill");
    endtask

`ifdef SOFTMC_RECV_MAINT_EN
    task automatic test_priority();
        bit got;
        start_seq();
        push_instr(32'hF000_00AA);
        rdback_fifo_empty = 1'b1;
        maint_en = 1'b1; maint_instr = 32'hF000_00AA;
        app_en   = 1'b1; app_instr   = 32'h1000_0005;
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (maint_ack || app_ack) begin got = 1'b1; break; end
        end
        maint_en = 1'b0;
        n_chk++;
        if (!got || maint_ack !== 1'b1 || app_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_maint_first: got maint_ack=%b app_ack=%b, expected 1/0", maint_ack, app_ack);
        end
        finish_seq("prio_maint");
        start_seq();
        push_instr(32'h1000_0005);
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (app_ack) begin got = 1'b1; break; end
        end
        app_en = 1'b0;
        n_chk++;
        if (!got) begin n_fail++; $display("FAIL prio_app_later: got no ack, expected ack"); end
        send(1'b0, 32'hF000_0005, "prio_app_end");
        finish_seq("prio_app");

        start_seq();
        push_instr(32'h1000_0006);
        rdback_fifo_empty = 1'b0;
        maint_en = 1'b1; maint_instr = 32'h1000_0007;
        app_en   = 1'b1; app_instr   = 32'h1000_0006;
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (maint_ack || app_ack) begin got = 1'b1; break; end
        end
        app_en = 1'b0;
        n_chk++;
        if (!got || app_ack !== 1'b1 || maint_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_rdback_gate: got maint_ack=%b app_ack=%b, expected 0/1", maint_ack, app_ack);
        end
        send(1'b0, 32'hF000_0006, "gate_end");
        finish_seq("rdback_gate");
        maint_en = 1'b0;
        rdback_fifo_empty = 1'b1;
    endtask
`else
    task automatic test_macro_off();
        int cnt0;
        cnt0 = maint_ack_cnt;
        maint_en = 1'b1; maint_instr = 32'hF000_0001;
        start_seq();
        send(1'b0, 32'h1000_0021, "off_i0");
        send(1'b0, 32'hF000_0022, "off_end");
        finish_seq("macro_off");
        n_chk++;
        if (maint_ack_cnt != cnt0) begin
            n_fail++;
            $display("FAIL macro_off_maint_ack: got %0d acks, expected 0", maint_ack_cnt - cnt0);
        end
        maint_en = 1'b0;
    endtask
`endif

    task automatic test_full_stall();
        int  acks;
        bit  got;
        start_seq();
        send(1'b0, 32'h3000_0001, "stall_i0");
        instr_fifo_full[1] = 1'b1;
        push_instr(32'h3000_0002);
        app_en = 1'b1; app_instr = 32'h3000_0002;
        acks = 0;
        repeat (5) begin
            @(negedge clk);
            if (app_ack) acks++;
        end
        n_chk++;
        if (acks != 0 || seq_err !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_blocked: got acks=%0d seq_err=%b, expected 0/1", acks, seq_err);
        end
        instr_fifo_full[1] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (app_ack) begin got = 1'b1; break; end
        end
        app_en = 1'b0;
        n_chk++;
        if (!got || seq_err !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: got ack=%b seq_err=%b, expected 1/1", got, seq_err);
        end
        send(1'b0, 32'hF000_0003, "stall_end");
        finish_seq("full_stall");
    endtask

    task automatic test_reset_mid_pad();
        start_seq();
        send(1'b0, 32'h4000_0001, "rpad_i0");
        send(1'b0, 32'h4000_0002, "rpad_i1");
        instr_fifo_full[1] = 1'b1;
        send(1'b0, 32'hF000_0004, "rpad_end");
        repeat (2) @(negedge clk);
        n_chk++;
        if (process_iseq !== 1'b0) begin
            n_fail++;
            $display("FAIL rpad_stalled: got process_iseq=%b, expected 0", process_iseq);
        end
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        n_chk++;
        if ({app_ack, maint_ack, instr_fifo_en, instr_fifo_data, process_iseq, iseq_rows, seq_err} !== '0) begin
            n_fail++;
            $display("FAIL rpad_outputs: got en=%b data=%h rows=%0d err=%b proc=%b, expected all 0",
                     instr_fifo_en, instr_fifo_data, iseq_rows, seq_err, process_iseq);
        end
        rst = 1'b0;
        instr_fifo_full = '0;
        @(negedge clk);
        start_seq();
        send(1'b0, 32'h5000_0001, "rpad_new_i0");
        n_chk++;
        if (iseq_rows !== 16'd0) begin
            n_fail++;
            $display("FAIL rpad_new_rows: got %0d, expected 0", iseq_rows);
        end
        send(1'b0, 32'hF000_0002, "rpad_new_end");
        finish_seq("rpad_new");
    endtask

    initial begin
        test_reset();
        test_app_seq();
        test_exact_fill();
`ifdef SOFTMC_RECV_MAINT_EN
        test_priority();
`else
        test_macro_off();
`endif
        test_full_stall();
        test_reset_mid_pad();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
